// File: rtl/booth_seq_if.sv
// booth_seq_if: valid/ready front end for the 8-bit Booth core; loads M then Q,
// collects the hi/lo product bytes and answers with a watchdog-guarded response.
module booth_seq_if #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_m,
    input  logic [7:0]  req_q,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_prod,
    output logic        rsp_err,
    output logic        core_bgn,
    output logic [7:0]  core_ibus,
    input  logic        core_stop,
    input  logic [7:0]  core_obus
);
    typedef enum logic [2:0] {IDLE, LDM0, LDM1, RUN, CAPH, CAPL, RESP} state_t;
    state_t           r_state, w_next;
    logic [7:0]       r_m, r_q, r_hi, r_lo;
    logic             r_err, r_stop_d;
    logic [CNT_W-1:0] r_wd;
    logic             w_stop_edge, w_expired;
    // a stop level left high by the previous op only counts after it has been seen low
    assign w_stop_edge = core_stop && !r_stop_d;
    assign w_expired   = r_wd == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req_valid ? LDM0 : IDLE;
            LDM0:    w_next = LDM1;
            LDM1:    w_next = RUN;
            RUN:     w_next = w_stop_edge ? CAPH : (w_expired ? RESP : RUN);
            CAPH:    w_next = CAPL;
            CAPL:    w_next = RESP;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_m      <= '0;
            r_q      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_err    <= 1'b0;
            r_stop_d <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_stop_d <= core_stop;
            if (r_state == IDLE && req_valid) begin
                r_m   <= req_m;
                r_q   <= req_q;
                r_err <= 1'b0;
            end
            if (r_state == LDM1) r_wd <= '0;
            if (r_state == RUN) r_wd <= r_wd + 1'b1;
            if (r_state == RUN && !w_stop_edge && w_expired) r_err <= 1'b1;
            if (r_state == CAPH) r_hi <= core_obus;
            if (r_state == CAPL) r_lo <= core_obus;
        end
    end
    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign core_bgn  = r_state == LDM0;
    assign core_ibus = (r_state == LDM0 || r_state == LDM1) ? r_m : (r_state == RUN ? r_q : 8'h00);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_prod  = (rsp_valid && !r_err) ? {r_hi, r_lo} : 16'h0000;
endmodule

// File: doc/booth_seq_if.md
Name: booth_seq_if

Overview:
- Upstream sequencer and result collector for the 8-bit radix-2 Booth multiplier core.
- Accepts a signed operand pair on a valid/ready request channel and issues the core start pulse.
- Serialises multiplicand M and multiplier Q onto the core's 8-bit input bus, then reassembles the two product bytes from the core's 8-bit output bus.
- Returns a 16-bit signed product on a valid/ready response channel, with a watchdog that flags a hung core.

Parameters:
- TIMEOUT, 64: maximum cycles in RUN waiting for core_stop before the error response; legal range 16..255.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_b, input, 1: asynchronous active-low reset.
- req_valid, input, 1: operand pair present.
- req_ready, output, 1: block can accept an operand pair.
- req_m, input, 8: multiplicand, two's complement.
- req_q, input, 8: multiplier, two's complement.
- rsp_valid, output, 1: result present.
- rsp_ready, input, 1: consumer accepts the result.
- rsp_prod, output, 16: signed product {hi, lo}.
- rsp_err, output, 1: watchdog expired; rsp_prod is 0.
- core_bgn, output, 1: one-cycle start pulse to the core.
- core_ibus, output, 8: operand bus to the core.
- core_stop, input, 1: core done flag; may remain high after completion.
- core_obus, input, 8: product byte bus from the core.

Behaviour:
- Reset (async, rst_b=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_prod=0; core_bgn=0; core_ibus=0; operand regs, byte regs and watchdog cleared. Reset mid-operation abandons the transaction silently; no response is produced.
- States: IDLE, LDM0, LDM1, RUN, CAPH, CAPL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_m/req_q and go to LDM0.
  - core_ibus=0.
- LDM0:
  - core_bgn=1 (only cycle it is high).
  - core_ibus=M.
  - Next state LDM1.
- LDM1: core_ibus=M; next state RUN; watchdog cleared.
- RUN:
  - core_ibus=Q, held stable for the whole state.
  - Watchdog increments each cycle.
  - Stop is detected on the rising edge only (core_stop=1 with the previous-cycle sample 0). A stop level that was already high at LDM0 is ignored until it has been seen low.
  - On the stop edge, go to CAPH.
  - If the watchdog reaches TIMEOUT first, go to RESP with rsp_err=1 and rsp_prod=0.
- CAPH: hi byte <= core_obus (the value present in the first cycle of RUN->CAPH transition, i.e. the stop-edge cycle's following cycle); next state CAPL.
- CAPL: lo byte <= core_obus; next state RESP.
- RESP:
  - rsp_valid=1; rsp_prod={hi,lo}; rsp_err as set.
  - Outputs are stable while rsp_ready=0.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- req_ready=0 in every state except IDLE, so there is no overlap or pipelining. Requests offered while busy are held off, not dropped.
- Latency: fixed 2 cycles plus core compute time plus 2 capture cycles plus 1 cycle to response, from request accept.
- No arithmetic is performed on the product; bytes are concatenated verbatim. Sign correctness is the core's responsibility.
- core_ibus is 0 in IDLE, CAPH, CAPL and RESP.

Test Plan:
- Accept M=5, Q=3 (core model returns 0x000F) -> core_bgn one pulse in LDM0; core_ibus=0x05,0x05,0x03...; rsp_prod=0x000F, rsp_err=0.
- M=0x80, Q=0x80 (-128*-128) -> rsp_prod=0x4000; M=0x07, Q=0xFF -> rsp_prod=0xFFF9.
- Hold rsp_ready=0 for 10 cycles with a second req_valid pending -> rsp_prod stable; req_ready=0 throughout; second request accepted in the cycle after the rsp handshake plus one.
- Core model never raises core_stop, TIMEOUT=64 -> rsp_valid exactly 64 cycles after entering RUN; rsp_err=1; rsp_prod=0x0000.
- core_stop held high from the previous op when a new op starts -> no false capture; product captured only after stop falls and rises again.
- Pull rst_b low in RUN -> all outputs at reset values immediately; no rsp_valid afterward; next request completes correctly.
